// File: rtl/l1_mac_seq.sv
// Sequential layer-1 MAC: streams N_IN pixels through N_OUT parallel lanes, then adds a bias.
// Optional build macro L1MAC_RELU_EN clamps negative lane results to zero before loading acc_bus.
`timescale 1ns/1ps
module l1_mac_seq #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 32,
    parameter int FRAC  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pix_valid,
    input  logic signed [31:0]    pix_data,
    output logic                  pix_ready,
    output logic [31:0]           ctr1,
    output logic                  re,
    input  logic [32*N_OUT-1:0]   w1_bus,
    output logic [32*N_OUT-1:0]   acc_bus,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [31:0]        cnt;
    logic               vld_p1, vld_p2, bias_p1, bias_p2;
    logic signed [31:0] pix_p1, pix_p2;
    logic signed [31:0] acc [N_OUT];
    logic signed [31:0] w_lane [N_OUT];
    logic signed [31:0] bias_sum [N_OUT];
    logic               accept, issue_bias;

    // Full 64-bit product, arithmetic shift back to Q-FRAC, truncate to 32 bits.
    function automatic logic signed [31:0] mac_term(input logic signed [31:0] p,
                                                    input logic signed [31:0] w);
        logic signed [63:0] prod;
        prod = p * w;
        return 32'(prod >>> FRAC);
    endfunction

    function automatic logic signed [31:0] finalize(input logic signed [31:0] v);
`ifdef L1MAC_RELU_EN
        return (v < 0) ? 32'sd0 : v;
`else
        return v;
`endif
    endfunction

    assign pix_ready  = (state == RUN) && (cnt < 32'(N_IN));
    assign accept     = pix_valid && pix_ready;
    assign issue_bias = (state == RUN) && (cnt == 32'(N_IN));
    assign re         = (state != IDLE);

    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            w_lane[i]   = $signed(w1_bus[32*i +: 32]);
            bias_sum[i] = acc[i] + w_lane[i];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = RUN;
            RUN:     if (issue_bias) state_nxt = DRAIN;
            DRAIN:   if (bias_p2)    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Stage 1 / stage 2 pixel data (no reset; qualified by vld_p1/vld_p2)
    always_ff @(posedge clk) begin
        if (accept)
            pix_p1 <= pix_data;
        pix_p2 <= pix_p1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ctr1    <= '0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            bias_p1 <= 1'b0;
            bias_p2 <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            acc_bus <= '0;
            for (int i = 0; i < N_OUT; i++)
                acc[i] <= '0;
        end else begin
            state   <= state_nxt;
            done    <= 1'b0;
            vld_p1  <= accept;
            vld_p2  <= vld_p1;
            bias_p1 <= issue_bias;
            bias_p2 <= bias_p1;
            if (accept) begin
                ctr1 <= cnt;
                cnt  <= cnt + 32'd1;
            end
            if (issue_bias)
                ctr1 <= 32'(N_IN);
            // Stage 2 -> accumulate; the memory output w1_bus lines up with pix_p2 here
            for (int i = 0; i < N_OUT; i++) begin
                if (vld_p2)
                    acc[i] <= acc[i] + mac_term(pix_p2, w_lane[i]);
                else if (bias_p2)
                    acc[i] <= bias_sum[i];
            end
            if (bias_p2) begin
                busy <= 1'b0;
                done <= 1'b1;
                for (int i = 0; i < N_OUT; i++)
                    acc_bus[32*i +: 32] <= finalize(bias_sum[i]);
            end
            if (state == IDLE && start) begin
                cnt  <= '0;
                busy <= 1'b1;
                for (int i = 0; i < N_OUT; i++)
                    acc[i] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_l1_mac_seq.sv
// Scoreboard bench for l1_mac_seq: directed images, expected results queued at start, checked on done.
`timescale 1ns/1ps
module tb_l1_mac_seq;
    localparam int N_IN = 4, N_OUT = 2, FRAC = 16;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, pix_valid = 1'b0;
    logic [31:0] pix_data = '0;
    logic        pix_ready, re, busy, done;
    logic [31:0] ctr1;
    logic [63:0] w1_bus = '0;
    logic [63:0] acc_bus;

    l1_mac_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .FRAC(FRAC)) dut (
        .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .ctr1(ctr1), .re(re),
        .w1_bus(w1_bus), .acc_bus(acc_bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight memory: registered 1-cycle read, entry N_IN is the bias
    logic [31:0] mem0 [0:4];
    logic [31:0] mem1 [0:4];
    always @(posedge clk)
        if (re) w1_bus <= (ctr1 < 32'd5) ? {mem1[ctr1[2:0]], mem0[ctr1[2:0]]} : 64'd0;

    typedef struct { logic [31:0] a0; logic [31:0] a1; int c; } exp_t;
    exp_t        q[$];
    logic [31:0] ctr_log[$];
    bit          log_en = 1'b0;
    int          nchecks = 0, nerrors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse, logs ctr1 changes
    initial begin
        exp_t        e;
        logic        prev_done = 1'b0;
        logic [31:0] prev_ctr = '0;
        forever begin
            @(negedge clk);
            if (log_en && ctr1 !== prev_ctr) ctr_log.push_back(ctr1);
            prev_ctr = ctr1;
            if (done === 1'b1) begin
                chk("done_width", {63'd0, prev_done}, 64'd0);
                if (q.size() == 0) begin
                    nchecks++;
                    nerrors++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending image", cyc);
                end else begin
                    e = q.pop_front();
                    chk("acc_lane0", {32'd0, acc_bus[31:0]}, {32'd0, e.a0});
                    chk("acc_lane1", {32'd0, acc_bus[63:32]}, {32'd0, e.a1});
                    chk("done_cycle", 64'(cyc), 64'(e.c));
                end
            end
            prev_done = done;
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_ctr1", {32'd0, ctr1}, 64'd0);
        chk("rst_re", {63'd0, re}, 64'd0);
        chk("rst_pix_ready", {63'd0, pix_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_acc_bus", acc_bus, 64'd0);
    endtask

    // Entered at a negedge; stalls of stall_len cycles go before pixel stall_after
    task automatic run_image(input int stall_after, input int stall_len, input bit poke,
                             input logic [31:0] e0, input logic [31:0] e1);
        exp_t e;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.a0 = e0;
        e.a1 = e1;
        e.c  = cyc + N_IN + 3 + stall_len;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        for (int i = 0; i < N_IN; i++) begin
            if (i == stall_after) begin
                pix_valid = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    start = poke;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            pix_valid = 1'b1;
            pix_data  = 32'h0001_0000;
            @(negedge clk);
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (busy === 1'b0 && q.size() == 0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            nchecks++;
            nerrors++;
            $display("FAIL wait_idle: busy=%0b pending=%0d after 60 cycles, required idle", busy, q.size());
        end
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            nchecks++;
            nerrors++;
            $display("FAIL wait_done: no done within 60 cycles, required a pulse");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] lane1_neg;
        for (int i = 0; i < 4; i++) begin
            mem0[i] = 32'h0002_0000;
            mem1[i] = 32'h0002_0000;
        end
        mem0[4] = 32'h0001_0000;
        mem1[4] = 32'h0001_0000;

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        reset = 1'b1;
        @(negedge clk);

        // 1: back-to-back pixels, 4 * (1.0*2.0) + 1.0 = 9.0
        run_image(N_IN, 0, 1'b0, 32'h0009_0000, 32'h0009_0000);
        wait_idle();

        // 2: three bubbles between pixels 1 and 2
        log_en = 1'b1;
        @(negedge clk);
        run_image(2, 3, 1'b0, 32'h0009_0000, 32'h0009_0000);
        wait_idle();
        log_en = 1'b0;
        chk("ctr1_seq_len", 64'(ctr_log.size()), 64'd5);
        for (int i = 0; i < ctr_log.size() && i < 5; i++)
            chk("ctr1_seq", {32'd0, ctr_log[i]}, 64'(i));

        // 3: lane 1 weights -2.0, bias 0 -> raw sum -8.0
        for (int i = 0; i < 4; i++) mem1[i] = 32'hFFFE_0000;
        mem1[4] = 32'h0000_0000;
`ifdef L1MAC_RELU_EN
        lane1_neg = 32'h0000_0000;
`else
        lane1_neg = 32'hFFF8_0000;
`endif
        @(negedge clk);
        run_image(N_IN, 0, 1'b0, 32'h0009_0000, lane1_neg);
        wait_idle();
        for (int i = 0; i < 4; i++) mem1[i] = 32'h0002_0000;
        mem1[4] = 32'h0001_0000;

        // 4: reset after two pixels, then a fresh image
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pix_valid = 1'b1;
        pix_data  = 32'h0001_0000;
        repeat (2) @(negedge clk);
        pix_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        @(negedge clk);
        chk_reset_outputs();
        reset = 1'b1;
        repeat (8) @(negedge clk);
        run_image(N_IN, 0, 1'b0, 32'h0009_0000, 32'h0009_0000);
        wait_idle();

        // 5: start while busy is ignored; start in the done cycle is taken
        @(negedge clk);
        run_image(2, 2, 1'b1, 32'h0009_0000, 32'h0009_0000);
        wait_done();
        run_image(N_IN, 0, 1'b0, 32'h0009_0000, 32'h0009_0000);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
